// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam logic [31:0] DefPattern = 32'h0000_0013;
  localparam int unsigned DefLen     = 5;
  localparam bit          DefOverlap = 1'b1;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Mask with the low `len` bits set; len >= 32 gives all ones.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) begin
      return '1;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear; clear has priority over increment.
module seq_match_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= (cnt_d == '1);
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with valid qualifier, overlap control
// and a saturating match counter. All outputs are registered.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DefPattern),
  parameter int unsigned        DEF_LEN     = DefLen,
  parameter bit                 DEF_OVERLAP = DefOverlap
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               IN,
  input  logic               CFG_LOAD,
  input  logic [MAX_LEN-1:0] CFG_PATTERN,
  input  logic [LEN_W-1:0]   CFG_LEN,
  input  logic               CFG_OVERLAP,
  input  logic               CNT_CLR,
  output logic               MATCH,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic               CNT_SAT
);

  // Only MAX_LEN-1 bits are stored: the oldest bit falls out of the window on the
  // very shift that would compare it, so the full MAX_LEN-bit history is hist_next.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_next, mask;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_next;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic               hit;

  always_comb begin
    hist_next = {hist_q, IN};
    fill_next = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask      = MAX_LEN'(len_mask(32'(len_q)));
    hit       = EN && !CFG_LOAD && (len_q != '0) && (fill_next >= len_q) &&
                (((hist_next ^ pat_q) & mask) == '0);

    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    match_d = 1'b0;

    if (CFG_LOAD) begin
      // The bit presented on a load cycle is dropped even when EN is high.
      pat_d  = CFG_PATTERN;
      len_d  = LEN_W'(clamp_len(32'(CFG_LEN), MAX_LEN));
      ovl_d  = CFG_OVERLAP;
      hist_d = '0;
      fill_d = '0;
    end else if (EN) begin
      hist_d  = hist_next[MAX_LEN-2:0];
      fill_d  = (hit && !ovl_q) ? '0 : fill_next;
      match_d = hit;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
      ovl_q   <= DEF_OVERLAP;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
    end
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .clr(CNT_CLR),
    .inc(hit),
    .cnt(MATCH_CNT),
    .sat(CNT_SAT)
  );

  assign MATCH = match_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model plus directed literal checks,
// run on an 8-bit-counter instance and a 2-bit-counter instance sharing one stimulus.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic               EN, IN, CFG_LOAD, CFG_OVERLAP, CNT_CLR;
  logic [MAX_LEN-1:0] CFG_PATTERN;
  logic [LEN_W-1:0]   CFG_LEN;
  logic               MATCH, CNT_SAT, match2, sat2;
  logic [7:0]         MATCH_CNT;
  logic [1:0]         cnt2;

  seq_detector_param dut (
    .CLK(CLK), .RST(RST), .EN(EN), .IN(IN), .CFG_LOAD(CFG_LOAD),
    .CFG_PATTERN(CFG_PATTERN), .CFG_LEN(CFG_LEN), .CFG_OVERLAP(CFG_OVERLAP),
    .CNT_CLR(CNT_CLR), .MATCH(MATCH), .MATCH_CNT(MATCH_CNT), .CNT_SAT(CNT_SAT)
  );

  seq_detector_param #(.CNT_W(2)) dut_c2 (
    .CLK(CLK), .RST(RST), .EN(EN), .IN(IN), .CFG_LOAD(CFG_LOAD),
    .CFG_PATTERN(CFG_PATTERN), .CFG_LEN(CFG_LEN), .CFG_OVERLAP(CFG_OVERLAP),
    .CNT_CLR(CNT_CLR), .MATCH(match2), .MATCH_CNT(cnt2), .CNT_SAT(sat2)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the valid bits received since the last restart, newest at the back.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         c8, c2;
  logic       exp_match;
  bit         chk_on = 1'b0;

  task automatic model_reset();
    q.delete();
    m_pat = 8'h13; m_len = 5; m_ovl = 1'b1;
    exp_match = 1'b0; c8 = 0; c2 = 0;
  endtask

  // Computes the outputs that must appear after the coming rising edge.
  task automatic model_step();
    bit hit;
    hit = 1'b0;
    if (CFG_LOAD) begin
      q.delete();
      m_pat = CFG_PATTERN;
      m_len = (int'(CFG_LEN) > MAX_LEN) ? MAX_LEN : int'(CFG_LEN);
      m_ovl = CFG_OVERLAP;
    end else if (EN) begin
      q.push_back(IN);
      if (q.size() > 64) void'(q.pop_front());
      if (m_len != 0 && q.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
      end
      if (hit && !m_ovl) q.delete();
    end
    exp_match = hit;
    if (CNT_CLR) begin
      c8 = 0; c2 = 0;
    end else if (hit) begin
      c8 = (c8 < 255) ? c8 + 1 : 255;
      c2 = (c2 < 3) ? c2 + 1 : 3;
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (chk_on && !RST) begin
      check("match", MATCH, exp_match);
      check("cnt8", MATCH_CNT, c8);
      check("sat8", CNT_SAT, c8 == 255);
      check("match_c2", match2, exp_match);
      check("cnt2", cnt2, c2);
      check("sat2", sat2, c2 == 3);
    end
  end

  task automatic cyc(input logic en, input logic in_b, input logic load = 1'b0,
                     input logic clr = 1'b0);
    @(negedge CLK);
    EN = en; IN = in_b; CFG_LOAD = load; CNT_CLR = clr;
    model_step();
    @(posedge CLK);
    #2;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic clr, input logic en = 1'b0, input logic in_b = 1'b0);
    CFG_PATTERN = pat; CFG_LEN = len; CFG_OVERLAP = ovl;
    cyc(en, in_b, 1'b1, clr);
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i]);
  endtask

  initial begin
    RST = 1'b1; EN = 0; IN = 0; CFG_LOAD = 0; CNT_CLR = 0;
    CFG_PATTERN = '0; CFG_LEN = '0; CFG_OVERLAP = 0;
    model_reset();
    chk_on = 1'b1;
    #1;
    check("reset_match", MATCH, 0);
    check("reset_cnt", MATCH_CNT, 0);
    check("reset_sat", CNT_SAT, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Default pattern 10011, overlapping.
    send(16'b10011, 5);
    check("t1_match_bit5", MATCH, 1);
    cyc(1'b1, 1'b0);
    check("t1_match_bit6", MATCH, 0);
    send(16'b011, 3);
    check("t1_match_bit9", MATCH, 1);
    check("t1_cnt", MATCH_CNT, 2);

    // Pattern 101, L=3, no overlap, then overlap.
    load_cfg(8'b0000_0101, 4'd3, 1'b0, 1'b1);
    send(16'b10101, 5);
    check("t2_cnt_noovl", MATCH_CNT, 1);
    load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b1);
    send(16'b10101, 5);
    check("t2_cnt_ovl", MATCH_CNT, 2);

    // EN gaps inside the default pattern.
    load_cfg(8'h13, 4'd5, 1'b1, 1'b1);
    send(16'b10, 2);
    repeat (3) cyc(1'b0, 1'($urandom));
    send(16'b01, 2);
    check("t3_no_early", MATCH, 0);
    cyc(1'b0, 1'b1);
    check("t3_en_low", MATCH, 0);
    cyc(1'b1, 1'b1);
    check("t3_match", MATCH, 1);
    check("t3_cnt", MATCH_CNT, 1);

    // Reconfig with L=12 clamps to 8; the load-cycle bit is discarded.
    send(16'b1001, 4);
    load_cfg(8'hCB, 4'd12, 1'b1, 1'b1, 1'b1, 1'b1);
    send(16'b1001011, 7);
    check("t4_discard", MATCH_CNT, 0);
    load_cfg(8'hCB, 4'd12, 1'b1, 1'b0);
    send(16'b1100101, 7);
    check("t4_not_before_8", MATCH_CNT, 0);
    cyc(1'b1, 1'b1);
    check("t4_match_at_8", MATCH, 1);
    check("t4_cnt", MATCH_CNT, 1);

    // Saturation: L=1 pattern "1", five matches.
    load_cfg(8'h01, 4'd1, 1'b1, 1'b1);
    repeat (5) cyc(1'b1, 1'b1);
    check("t5_cnt8", MATCH_CNT, 5);
    check("t5_sat8", CNT_SAT, 0);
    check("t5_cnt2", cnt2, 3);
    check("t5_sat2", sat2, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_clr_match", MATCH, 1);
    check("t5_clr_cnt8", MATCH_CNT, 0);
    check("t5_clr_cnt2", cnt2, 0);
    check("t5_clr_sat2", sat2, 0);
    load_cfg(8'h01, 4'd0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1);
    check("t5_len0_match", MATCH, 0);
    check("t5_len0_cnt", MATCH_CNT, 0);

    // Asynchronous reset mid-pattern.
    load_cfg(8'h13, 4'd5, 1'b1, 1'b0);
    send(16'b10011, 5);
    send(16'b1001, 4);
    EN = 0; IN = 0; CFG_LOAD = 0; CNT_CLR = 0;
    RST = 1'b1;
    #1;
    model_reset();
    check("t6_rst_match", MATCH, 0);
    check("t6_rst_cnt", MATCH_CNT, 0);
    @(negedge CLK);
    RST = 1'b0;
    cyc(1'b1, 1'b1);
    check("t6_single_one", MATCH, 0);
    send(16'b10011, 5);
    check("t6_full_match", MATCH, 1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        CFG_PATTERN = 8'($urandom);
        CFG_LEN = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 4));
        CFG_OVERLAP = 1'($urandom);
        cyc(1'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 3) == 0);
      end else begin
        cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'b0, $urandom_range(0, 31) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 5-bit "10011" FSM detector.
- Pattern, length and overlap mode are runtime-configurable.
- Adds an input-valid qualifier and a saturating match counter.
- Sits on a serial input stream; MATCH pulses feed downstream framing/sync logic, MATCH_CNT feeds status registers.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, width of the match counter.
- DEF_PATTERN, 8'b0001_0011, pattern loaded at reset (right-aligned).
- DEF_LEN, 5, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  IN is valid this cycle.
- IN  in  1  serial data bit.
- CFG_LOAD  in  1  latch the CFG_* inputs into the active config.
- CFG_PATTERN  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- CFG_LEN  in  LEN_W  pattern length.
- CFG_OVERLAP  in  1  1 = overlapping matches allowed, 0 = history restarts after each match.
- CNT_CLR  in  1  synchronous clear of MATCH_CNT.
- MATCH  out  1  registered one-cycle pulse per detected match.
- MATCH_CNT  out  CNT_W  saturating count of matches.
- CNT_SAT  out  1  high while MATCH_CNT is all-ones.

Behaviour:
- Clock and reset: RST is asynchronous, active-high; all state is on the rising edge of CLK.
- Reset values:
  - MATCH=0, MATCH_CNT=0, CNT_SAT=0.
  - History register=0, fill count=0.
  - Active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
- Effective length L:
  - L = CFG_LEN clamped to MAX_LEN at load.
  - L=0 means the detector is disabled: MATCH never asserts.
  - L=1 is legal.
- History: MAX_LEN-bit shift register plus a fill counter saturating at MAX_LEN.
  - On an edge with EN=1: hist_next = {hist[MAX_LEN-2:0], IN}; fill increments.
  - On an edge with EN=0: history, fill and counter hold; MATCH <= 0.
- Match condition, evaluated on hist_next on an EN=1 edge:
  - fill_next >= L, L != 0, and hist_next[L-1:0] == pattern[L-1:0].
  - When true, MATCH <= 1 at that same edge, so MATCH is high in the cycle after the last pattern bit is sampled.
  - Latency is identical to the legacy FSM detector.
- Overlap mode:
  - Overlap=1: history keeps shifting after a match. Example: "100110011" with pattern 10011 gives 2 matches.
  - Overlap=0: on a match, fill is forced to 0. The next match requires L fresh bits, and the matching bits are not reused.
- Config load:
  - CFG_LOAD=1 latches the CFG_* inputs and clears history, fill and MATCH.
  - The IN bit on the load cycle is discarded, even if EN=1.
  - MATCH_CNT is not affected by a config load.
- Counter:
  - Increments on each MATCH assertion, i.e. on the edge where MATCH is set.
  - Saturates at 2^CNT_W-1; CNT_SAT is registered alongside it.
  - CNT_CLR sets the counter to 0.
  - CNT_CLR together with a match on the same edge: clear wins, count=0.
  - CNT_CLR together with CFG_LOAD: both take effect.
- Reset mid-stream: the partial history is lost and the next match needs L new bits.
- No combinational path from inputs to outputs.

Decomposition:
- Package seq_det_pkg:
  - Default pattern, length and overlap constants.
  - A function that clamps the length.
  - A function that builds a low-L-bit mask.
- Sub-module seq_match_counter (CNT_W): saturating counter with clear and inc inputs, CNT and SAT outputs.
- Top module target: about 150-250 lines.

Test Plan:
- Reset defaults, overlap on: stream IN = 1,0,0,1,1,0,0,1,1 with EN=1 -> MATCH pulses the cycle after bit 5 and after bit 9; MATCH_CNT=2.
- Load pattern 8'b0000_0101, L=3, overlap=0; stream 1,0,1,0,1 -> exactly one MATCH, after bit 3; with overlap=1 the same stream gives 2 matches.
- EN gaps: the default pattern with EN=0 inserted for 3 cycles between bits 2 and 3 -> still matches; MATCH asserts only on the EN=1 edge of bit 5.
- Reconfig: assert CFG_LOAD with L=12 (MAX_LEN=8) after bits 1,0,0,1 have been sent -> L clamps to 8; the first match is no earlier than 8 bits after the load; the bit on the load cycle is ignored.
- Counter: CNT_W=2, run 5 matches -> MATCH_CNT stays at 3 and CNT_SAT=1; CNT_CLR on the same edge as a match -> MATCH_CNT=0.
- Async reset mid-pattern after bits 1,0,0,1 -> MATCH=0 and MATCH_CNT=0 immediately; feeding a single 1 gives no match; a full 1,0,0,1,1 gives a match.
